// File: rtl/bounce_generator_if.sv
// Command/status bundle between a bounce_generator and whatever drives it.
// The master issues start requests; the slave (the generator) drives the bouncy line and status.
interface bounce_generator_if #(
    parameter int PLEN_W = 8,
    parameter int NB_W   = 4
);
    logic              start;
    logic              target;
    logic [NB_W-1:0]   nbounce;
    logic [PLEN_W-1:0] plen;
    logic              noisysignal;
    logic              busy;
    logic              done;

    modport master (
        output start, target, nbounce, plen,
        input  noisysignal, busy, done
    );

    modport slave (
        input  start, target, nbounce, plen,
        output noisysignal, busy, done
    );
endinterface

// File: rtl/bounce_generator.sv
// Drives a deliberately bouncy line: N glitch pairs of P cycles each, then settles on target.
// Define BOUNCE_JITTER_EN to stretch every phase by 0..3 cycles from an 8-bit LFSR.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line holds last settled level, waiting for start
// S_HI     | bounce phase with line = target
// S_LO     | bounce phase with line = ~target
// S_SETTLE | single done cycle, line = target; accepts start like idle
module bounce_generator #(
    parameter int PLEN_W = 8,
    parameter int NB_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    bounce_generator_if.slave   bus
);

`ifdef BOUNCE_JITTER_EN
    localparam int PH_W = PLEN_W + 1;
`else
    localparam int PH_W = PLEN_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HI     = 2'd1,
        S_LO     = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [NB_W-1:0]   bc_q, bc_d;
    logic              tgt_q, tgt_d;
    logic [PLEN_W-1:0] pl_q, pl_d;
    logic              noisy_q, noisy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic [PLEN_W-1:0] plen_m1;
    logic [PH_W-1:0]   load_new;
    logic [PH_W-1:0]   load_cur;

    // pl_q holds P-1 so a zero plen behaves as a one-cycle phase
    assign plen_m1 = (bus.plen == '0) ? '0 : bus.plen - PLEN_W'(1);
    assign accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_SETTLE));

`ifdef BOUNCE_JITTER_EN
    logic [7:0] lfsr_q;
    logic       lfsr_fb;

    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign load_new = PH_W'(plen_m1) + PH_W'(lfsr_q[1:0]);
    assign load_cur = PH_W'(pl_q) + PH_W'(lfsr_q[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
`else
    assign load_new = PH_W'(plen_m1);
    assign load_cur = PH_W'(pl_q);
`endif

    // state, counters and the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            bc_q    <= '0;
            tgt_q   <= 1'b0;
            pl_q    <= '0;
            noisy_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bc_q    <= bc_d;
            tgt_q   <= tgt_d;
            pl_q    <= pl_d;
            noisy_q <= noisy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bc_d    = bc_q;
        tgt_d   = tgt_q;
        pl_d    = pl_q;
        case (state_q)
            S_IDLE, S_SETTLE: begin
                state_d = S_IDLE;
                if (accept) begin
                    tgt_d = bus.target;
                    pl_d  = plen_m1;
                    if ((bus.target != noisy_q) && (bus.nbounce != '0)) begin
                        state_d = S_HI;
                        ph_d    = load_new;
                        bc_d    = bus.nbounce;
                    end
                end
            end
            S_HI: begin
                if (ph_q == '0) begin
                    state_d = S_LO;
                    ph_d    = load_cur;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            S_LO: begin
                if (ph_q == '0) begin
                    bc_d = bc_q - NB_W'(1);
                    if (bc_q == NB_W'(1)) begin
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_HI;
                        ph_d    = load_cur;
                    end
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs are computed from the upcoming state so they line up with it once registered
    always_comb begin
        noisy_d = noisy_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            S_HI: begin
                noisy_d = tgt_d;
                busy_d  = 1'b1;
            end
            S_LO: begin
                noisy_d = ~tgt_d;
                busy_d  = 1'b1;
            end
            S_SETTLE: begin
                noisy_d = tgt_d;
                done_d  = 1'b1;
            end
            default: begin
                if (accept) begin
                    noisy_d = bus.target;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    assign bus.noisysignal = noisy_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator with exact (jitter-free) timing.
module tb_bounce_generator;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    bounce_generator_if #(.PLEN_W(8), .NB_W(4)) bus ();

    bounce_generator #(.PLEN_W(8), .NB_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {bus.noisysignal, bus.busy, bus.done};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed{line,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // cycle k after the accepting edge: phases of P cycles alternate target/~target, then done
    function automatic logic [2:0] exp_vec(input logic tgt, input int n, input int p, input int k);
        if (k <= 2 * n * p) return {((((k - 1) / p) % 2) == 0) ? tgt : ~tgt, 1'b1, 1'b0};
        return {tgt, 1'b0, 1'b1};
    endfunction

    // Issues a start, then checks cycles 1..last; returns while sitting in cycle 'last'.
    task automatic run_train(input logic tgt, input int n, input int plen_in,
                             input int inject_at, input int stop_at, input string tag);
        int p;
        int last;
        p    = (plen_in == 0) ? 1 : plen_in;
        last = (stop_at != 0) ? stop_at : 2 * n * p + 1;
        bus.start   = 1'b1;
        bus.target  = tgt;
        bus.nbounce = 4'(n);
        bus.plen    = 8'(plen_in);
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            check($sformatf("%s c%0d", tag, k), exp_vec(tgt, n, p, k));
            if (k < last) begin
                if (k == inject_at) begin
                    bus.start   = 1'b1;
                    bus.target  = ~tgt;
                    bus.nbounce = 4'd1;
                    bus.plen    = 8'd7;
                end
                tick();
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [2:0] exp2 [13];
        exp2 = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b110, 3'b110, 3'b010,
                 3'b010, 3'b110, 3'b110, 3'b010, 3'b010, 3'b101};
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.target  = 1'b0;
        bus.nbounce = '0;
        bus.plen    = '0;

        // reset held, then idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold %0d", i), 3'b000);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle %0d", i), 3'b000);
        end

        // target=1, N=3, P=2 against the hand-written sequence
        bus.start = 1'b1; bus.target = 1'b1; bus.nbounce = 4'd3; bus.plen = 8'd2;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("t2 c%0d", k), exp2[k-1]);
            tick();
        end
        check("t2 after", 3'b100);

        // nbounce=0 transitions and same-level requests
        run_train(1'b0, 0, 4, 0, 0, "t3 n0 to0");
        tick();
        check("t3 n0 to0 after", 3'b000);
        run_train(1'b1, 0, 4, 0, 0, "t3 n0 to1");
        tick();
        check("t3 n0 to1 after", 3'b100);
        run_train(1'b1, 0, 4, 0, 0, "t3 same");
        tick();
        check("t3 same after", 3'b100);
        bus.start = 1'b1; bus.target = 1'b1; bus.nbounce = 4'd3; bus.plen = 8'd2;
        tick();
        bus.start = 1'b0;
        check("t3 same n3", 3'b101);
        tick();
        check("t3 same n3 after", 3'b100);

        // start during busy ignored; start in the done cycle accepted
        run_train(1'b0, 3, 2, 5, 0, "t4");
        bus.start = 1'b1; bus.target = 1'b1; bus.nbounce = 4'd0; bus.plen = 8'd0;
        tick();
        bus.start = 1'b0;
        check("t4 b2b", 3'b101);
        tick();
        check("t4 b2b after", 3'b100);

        // plen=0 behaves as one-cycle phases
        run_train(1'b0, 2, 0, 0, 0, "plen0");
        tick();
        check("plen0 after", 3'b000);

        // fastest train: N=4, P=1
        run_train(1'b1, 4, 1, 0, 0, "t6");
        tick();
        check("t6 after", 3'b100);

        // async reset aborts a train mid-flight
        run_train(1'b0, 5, 3, 0, 7, "t5");
        #2;
        reset = 1'b1;
        #1;
        check("t5 async rst", 3'b000);
        #1;
        reset = 1'b0;
        tick();
        check("t5 post rst idle", 3'b000);
        run_train(1'b1, 0, 4, 0, 0, "t5 restart");
        tick();
        check("t5 restart after", 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
